// File: rtl/complex_div_seq_if.sv
// Start/done handshake and operand/result bundle for the sequential complex divider.
interface complex_div_seq_if #(parameter int W = 32);
  logic         start;
  logic [W-1:0] ar, ai, br, bi;
  logic         busy, done;
  logic [W-1:0] cr, ci;
  logic         div_by_zero, overflow;

  modport master (output start, ar, ai, br, bi,
                  input  busy, done, cr, ci, div_by_zero, overflow);
  modport slave  (input  start, ar, ai, br, bi,
                  output busy, done, cr, ci, div_by_zero, overflow);
endinterface

// File: rtl/complex_div_seq.sv
// Sequential signed fixed-point complex divide C = A/B: one shared multiplier
// builds conj-products, then two restoring dividers share the denominator.
module complex_div_seq #(
  parameter int W    = 32,
  parameter int FRAC = 16
) (
  input  logic           clk,
  input  logic           rst,
  complex_div_seq_if.slave io
);
  localparam int PW = 2*W + 1;
  localparam int RW = 2*W;
  localparam int CW = $clog2(W) + 1;

  typedef enum logic [2:0] {IDLE, MUL, CHECK, DIV, FIN} state_t;
  state_t state, state_nx;

  logic [CW-1:0]        cnt;
  logic signed [W-1:0]  ar_q, ai_q, br_q, bi_q;
  logic signed [W-1:0]  m_a, m_b;
  logic signed [RW-1:0] prod;
  logic signed [PW-1:0] prod_x;
  logic signed [PW-1:0] nr, ni, den;
  logic [PW-1:0]        den_u, mag_r, mag_i, shr_r, shr_i;
  logic [RW-1:0]        rem_r, rem_i;
  logic [PW-1:0]        rem_sh_r, rem_sh_i;
  logic                 ge_r, ge_i;
  logic [W-1:0]         lo_r, lo_i, q_r, q_i;
  logic                 neg_r, neg_i, sat_r, sat_i, dz;
  logic [W:0]           fin_r, fin_i;
  logic [W-1:0]         cr_q, ci_q;
  logic                 done_q, dbz_q, ovf_q;

  // Returns {saturated, value}: applies sign to |q| and clamps to the W-bit range.
  function automatic logic [W:0] apply_sign(input logic [W-1:0] q, input logic neg,
                                            input logic pre);
    logic [W-1:0] maxp, minn;
    maxp = {1'b0, {(W-1){1'b1}}};
    minn = {1'b1, {(W-1){1'b0}}};
    if (pre)  return {1'b1, neg ? minn : maxp};
    if (!neg) return (q > maxp) ? {1'b1, maxp} : {1'b0, q};
    return (q > minn) ? {1'b1, minn} : {1'b0, -q};
  endfunction

  always_comb begin
    m_a = bi_q;
    m_b = bi_q;
    case (cnt)
      CW'(0): begin m_a = ar_q; m_b = br_q; end
      CW'(1): begin m_a = ai_q; m_b = bi_q; end
      CW'(2): begin m_a = ai_q; m_b = br_q; end
      CW'(3): begin m_a = ar_q; m_b = bi_q; end
      CW'(4): begin m_a = br_q; m_b = br_q; end
      default: ;
    endcase
    prod   = m_a * m_b;
    prod_x = PW'(prod);
  end

  always_comb begin
    den_u = $unsigned(den);
    mag_r = nr[PW-1] ? $unsigned(-nr) : $unsigned(nr);
    mag_i = ni[PW-1] ? $unsigned(-ni) : $unsigned(ni);
    // floor(|N|/2^(W-FRAC)) >= D is exactly q >= 2^W; it is also the divider's seed remainder
    shr_r = mag_r >> (W - FRAC);
    shr_i = mag_i >> (W - FRAC);
    rem_sh_r = {rem_r, lo_r[W-1]};
    rem_sh_i = {rem_i, lo_i[W-1]};
    ge_r = rem_sh_r >= den_u;
    ge_i = rem_sh_i >= den_u;
    fin_r = apply_sign(q_r, neg_r, sat_r);
    fin_i = apply_sign(q_i, neg_i, sat_i);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (io.start) state_nx = MUL;
      MUL:   if (cnt == CW'(5)) state_nx = CHECK;
      CHECK: state_nx = (den == '0) ? FIN : DIV;
      DIV:   if (cnt == CW'(W-1)) state_nx = FIN;
      FIN:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      ar_q <= '0; ai_q <= '0; br_q <= '0; bi_q <= '0;
      nr <= '0; ni <= '0; den <= '0;
      rem_r <= '0; rem_i <= '0; lo_r <= '0; lo_i <= '0; q_r <= '0; q_i <= '0;
      neg_r <= 1'b0; neg_i <= 1'b0; sat_r <= 1'b0; sat_i <= 1'b0; dz <= 1'b0;
      cr_q <= '0; ci_q <= '0; done_q <= 1'b0; dbz_q <= 1'b0; ovf_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (io.start) begin
          ar_q <= io.ar; ai_q <= io.ai; br_q <= io.br; bi_q <= io.bi;
          cnt <= '0;
          dbz_q <= 1'b0;
          ovf_q <= 1'b0;
        end
        MUL: begin
          case (cnt)
            CW'(0): nr  <= prod_x;
            CW'(1): nr  <= nr + prod_x;
            CW'(2): ni  <= prod_x;
            CW'(3): ni  <= ni - prod_x;
            CW'(4): den <= prod_x;
            default: den <= den + prod_x;
          endcase
          cnt <= (cnt == CW'(5)) ? '0 : cnt + 1'b1;
        end
        CHECK: begin
          dz    <= (den == '0);
          neg_r <= nr[PW-1];
          neg_i <= ni[PW-1];
          sat_r <= shr_r >= den_u;
          sat_i <= shr_i >= den_u;
          rem_r <= RW'(shr_r);
          rem_i <= RW'(shr_i);
          lo_r  <= mag_r[W-1:0] << FRAC;
          lo_i  <= mag_i[W-1:0] << FRAC;
          q_r   <= '0;
          q_i   <= '0;
          cnt   <= '0;
        end
        DIV: begin
          rem_r <= RW'(ge_r ? rem_sh_r - den_u : rem_sh_r);
          rem_i <= RW'(ge_i ? rem_sh_i - den_u : rem_sh_i);
          lo_r  <= lo_r << 1;
          lo_i  <= lo_i << 1;
          q_r   <= {q_r[W-2:0], ge_r};
          q_i   <= {q_i[W-2:0], ge_i};
          cnt   <= cnt + 1'b1;
        end
        FIN: begin
          done_q <= 1'b1;
          if (dz) begin
            cr_q <= '0; ci_q <= '0; dbz_q <= 1'b1; ovf_q <= 1'b0;
          end else begin
            cr_q  <= fin_r[W-1:0];
            ci_q  <= fin_i[W-1:0];
            ovf_q <= fin_r[W] | fin_i[W];
          end
        end
        default: ;
      endcase
    end
  end

  assign io.busy        = (state != IDLE);
  assign io.done        = done_q;
  assign io.cr          = cr_q;
  assign io.ci          = ci_q;
  assign io.div_by_zero = dbz_q;
  assign io.overflow    = ovf_q;
endmodule

// File: tb/tb_complex_div_seq.sv
// Randomized bench for complex_div_seq against an exact-rational reference model.
module tb_complex_div_seq;
  localparam int W = 32;
  localparam int FRAC = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0, n_pass = 0;
  logic [31:0] obs_cr, obs_ci;
  logic obs_dz, obs_ov;

  complex_div_seq_if #(.W(W)) io ();
  complex_div_seq #(.W(W), .FRAC(FRAC)) dut (.clk(clk), .rst(rst), .io(io));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] cdiv(input logic signed [127:0] n, input logic signed [127:0] d,
                                       output logic s);
    logic [127:0] mag, du, q;
    logic neg;
    neg = (n < 0);
    mag = neg ? -n : n;
    du  = d;
    q   = (mag << FRAC) / du;
    s   = 1'b0;
    if (!neg) begin
      if (q > 128'h7FFF_FFFF) begin s = 1'b1; return 32'h7FFF_FFFF; end
      return q[31:0];
    end
    if (q > 128'h8000_0000) begin s = 1'b1; return 32'h8000_0000; end
    return 32'h0 - q[31:0];
  endfunction

  function automatic void model(input logic [31:0] a_r, a_i, b_r, b_i,
                                output logic [31:0] ecr, eci, output logic edz, eov);
    logic signed [127:0] xr, xi, yr, yi, nr, ni, d;
    logic sr, si;
    xr = $signed(a_r); xi = $signed(a_i); yr = $signed(b_r); yi = $signed(b_i);
    nr = xr*yr + xi*yi;
    ni = xi*yr - xr*yi;
    d  = yr*yr + yi*yi;
    if (d == 0) begin
      ecr = '0; eci = '0; edz = 1'b1; eov = 1'b0;
    end else begin
      ecr = cdiv(nr, d, sr);
      eci = cdiv(ni, d, si);
      edz = 1'b0;
      eov = sr | si;
    end
  endfunction

  task automatic do_op(input string tag, input logic [31:0] a_r, a_i, b_r, b_i,
                       input int restart_at);
    logic [31:0] ecr, eci;
    logic edz, eov;
    int k;
    bit got;
    model(a_r, a_i, b_r, b_i, ecr, eci, edz, eov);
    @(negedge clk);
    io.ar = a_r; io.ai = a_i; io.br = b_r; io.bi = b_i; io.start = 1'b1;
    @(posedge clk); #1;
    io.start = 1'b0;
    io.ar = $urandom; io.ai = $urandom; io.br = $urandom; io.bi = $urandom;
    chk({tag, "_busy"}, 64'(io.busy), 64'd1);
    chk({tag, "_flagclr"}, 64'({io.div_by_zero, io.overflow}), 64'd0);
    k = 0; got = 0;
    while (!got && k < 200) begin
      @(posedge clk); #1;
      k++;
      if (io.done) got = 1;
      if (k == restart_at) begin
        io.start = 1'b1; io.ar = $urandom; io.ai = $urandom; io.br = $urandom; io.bi = $urandom;
      end
      if (k == restart_at + 1) io.start = 1'b0;
    end
    chk({tag, "_lat"}, 64'(k), edz ? 64'd8 : 64'(W + 8));
    chk({tag, "_cr"}, 64'(io.cr), 64'(ecr));
    chk({tag, "_ci"}, 64'(io.ci), 64'(eci));
    chk({tag, "_flags"}, 64'({io.div_by_zero, io.overflow}), 64'({edz, eov}));
    obs_cr = io.cr; obs_ci = io.ci; obs_dz = io.div_by_zero; obs_ov = io.overflow;
    @(posedge clk); #1;
    chk({tag, "_pulse"}, 64'({io.done, io.busy}), 64'd0);
  endtask

  function automatic logic [31:0] rnd_val(input int sel);
    logic [31:0] r, ext;
    logic [31:0] tbl [6];
    tbl[0] = 32'h8000_0000; tbl[1] = 32'h7FFF_FFFF; tbl[2] = 32'h0;
    tbl[3] = 32'h1;         tbl[4] = 32'hFFFF_FFFF; tbl[5] = 32'h0001_0000;
    r = $urandom;
    ext = {{12{r[19]}}, r[19:0]};
    case (sel)
      0: return r;
      1: return ext;
      default: return tbl[$urandom_range(0, 5)];
    endcase
  endfunction

  initial begin
    bit ok;
    logic [31:0] a_r, a_i, b_r, b_i;
    io.start = 1'b0; io.ar = '0; io.ai = '0; io.br = '0; io.bi = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_state", 64'({io.busy, io.done, io.div_by_zero, io.overflow}), 64'd0);
    chk("rst_cr", 64'({io.cr, io.ci}), 64'd0);

    do_op("t1", 32'h0001_0000, 32'h0, 32'h0, 32'h0001_0000, -1);
    chk("t1_const", 64'({obs_cr, obs_ci}), {32'h0, 32'hFFFF_0000});
    do_op("t2", 32'h0003_0000, 32'h0004_0000, 32'h0001_0000, 32'h0002_0000, -1);
    chk("t2_const", 64'({obs_cr, obs_ci}), {32'h0002_3333, 32'hFFFF_999A});
    do_op("dbz", 32'h0002_8000, 32'hFFFF_0000, 32'h0, 32'h0, -1);
    chk("dbz_const", 64'({obs_dz, obs_ov, obs_cr, obs_ci}), {2'b10, 64'h0});
    do_op("satp", 32'h7FFF_0000, 32'h0, 32'h1, 32'h0, -1);
    chk("satp_const", 64'({obs_ov, obs_cr}), {1'b1, 32'h7FFF_FFFF});
    do_op("satn", 32'h8000_0000, 32'h0, 32'h1, 32'h0, -1);
    chk("satn_const", 64'({obs_ov, obs_cr}), {1'b1, 32'h8000_0000});
    do_op("zero", 32'h0, 32'h0, 32'h1234_5678, 32'hFEDC_BA98, -1);
    do_op("ign", 32'h0003_0000, 32'h0004_0000, 32'h0001_0000, 32'h0002_0000, 5);
    chk("ign_const", 64'({obs_cr, obs_ci}), {32'h0002_3333, 32'hFFFF_999A});

    // Abort mid-operation; no done may follow.
    @(negedge clk);
    io.ar = 32'h0005_0000; io.ai = 32'h0001_0000; io.br = 32'h0002_0000; io.bi = 32'h0; io.start = 1'b1;
    @(posedge clk); #1 io.start = 1'b0;
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_state", 64'({io.busy, io.done, io.div_by_zero, io.overflow}), 64'd0);
    chk("abort_res", 64'({io.cr, io.ci}), 64'd0);
    rst = 1'b0;
    ok = 1;
    repeat (60) begin @(posedge clk); #1; if (io.done) ok = 0; end
    chk("abort_nodone", 64'(ok), 64'd1);
    do_op("post", 32'hFFFD_0000, 32'h0000_8000, 32'h0000_4000, 32'hFFFF_C000, -1);

    for (int i = 0; i < 700; i++) begin
      int sel;
      sel = $urandom_range(0, 2);
      a_r = rnd_val(sel); a_i = rnd_val(sel);
      b_r = rnd_val($urandom_range(0, 2)); b_i = rnd_val($urandom_range(0, 2));
      if ($urandom_range(0, 15) == 0) begin b_r = '0; b_i = '0; end
      do_op("rnd", a_r, a_i, b_r, b_i, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
